// File: rtl/ecc_apb_cmd_seq.sv
// Command sequencer for the ECC block: turns one accepted job into an APB write
// burst (CTRL last), waits for operation_done or a timeout, and returns the result.
module ecc_apb_cmd_seq #(
   parameter int unsigned AMBA_ADDR_WIDTH = 20,
   parameter int unsigned AMBA_WORD       = 32,
   parameter int unsigned DATA_WIDTH      = 32,
   parameter int unsigned TIMEOUT_CYCLES  = 16
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       cmd_valid,
   output logic                       cmd_ready,
   input  logic [1:0]                 cmd_op,
   input  logic [1:0]                 cmd_width,
   input  logic [AMBA_WORD-1:0]       cmd_data,
   input  logic [AMBA_WORD-1:0]       cmd_noise,
   output logic [AMBA_ADDR_WIDTH-1:0] PADDR,
   output logic [AMBA_WORD-1:0]       PWDATA,
   output logic                       PSEL,
   output logic                       PENABLE,
   output logic                       PWRITE,
   input  logic                       operation_done,
   input  logic [DATA_WIDTH-1:0]      data_out,
   input  logic [1:0]                 num_of_errors,
   output logic                       rsp_valid,
   input  logic                       rsp_ready,
   output logic [DATA_WIDTH-1:0]      rsp_data,
   output logic [1:0]                 rsp_nerr,
   output logic                       rsp_timeout,
   output logic                       busy
);

   localparam int unsigned CNT_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

   localparam logic [1:0] IDX_WIDTH = 2'd0;
   localparam logic [1:0] IDX_NOISE = 2'd1;
   localparam logic [1:0] IDX_DATA  = 2'd2;
   localparam logic [1:0] IDX_CTRL  = 2'd3;
   localparam logic [1:0] OP_FULL   = 2'b10;

   typedef enum logic [2:0] {
      S_IDLE,
      S_SETUP,
      S_ACCESS,
      S_WAIT_DONE,
      S_RESP
   } state_e;

   state_e                      state_q, state_d;
   logic [1:0]                  idx_q, idx_d;
   logic [CNT_W-1:0]            cnt_q, cnt_d;
   logic [1:0]                  op_q, op_d;
   logic [1:0]                  width_q, width_d;
   logic [AMBA_WORD-1:0]        data_q, data_d;
   logic [AMBA_WORD-1:0]        noise_q, noise_d;
   logic                        rsp_valid_q, rsp_valid_d;
   logic [DATA_WIDTH-1:0]       rsp_data_q, rsp_data_d;
   logic [1:0]                  rsp_nerr_q, rsp_nerr_d;
   logic                        rsp_timeout_q, rsp_timeout_d;
   logic                        psel_q, psel_d;
   logic                        penable_q, penable_d;
   logic                        pwrite_q, pwrite_d;
   logic [AMBA_ADDR_WIDTH-1:0]  paddr_q, paddr_d;
   logic [AMBA_WORD-1:0]        pwdata_q, pwdata_d;
   logic                        busy_q, busy_d;
   logic                        bus_act;

   // Register map of the ECC block, indexed by write-list position
   function automatic logic [AMBA_ADDR_WIDTH-1:0] entry_addr(input logic [1:0] idx);
      case (idx)
         IDX_WIDTH: entry_addr = AMBA_ADDR_WIDTH'(8'h08);
         IDX_NOISE: entry_addr = AMBA_ADDR_WIDTH'(8'h0C);
         IDX_DATA:  entry_addr = AMBA_ADDR_WIDTH'(8'h04);
         default:   entry_addr = AMBA_ADDR_WIDTH'(8'h00);
      endcase
   endfunction

   function automatic logic [AMBA_WORD-1:0] entry_data(input logic [1:0]           idx,
                                                       input logic [1:0]           op,
                                                       input logic [1:0]           width,
                                                       input logic [AMBA_WORD-1:0] data,
                                                       input logic [AMBA_WORD-1:0] noise);
      case (idx)
         IDX_WIDTH: entry_data = AMBA_WORD'(width);
         IDX_NOISE: entry_data = noise;
         IDX_DATA:  entry_data = data;
         default:   entry_data = AMBA_WORD'(op);
      endcase
   endfunction

   assign cmd_ready = (state_q == S_IDLE) & ~rst;

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q       <= S_IDLE;
         idx_q         <= '0;
         cnt_q         <= '0;
         op_q          <= '0;
         width_q       <= '0;
         data_q        <= '0;
         noise_q       <= '0;
         rsp_valid_q   <= 1'b0;
         rsp_data_q    <= '0;
         rsp_nerr_q    <= '0;
         rsp_timeout_q <= 1'b0;
         psel_q        <= 1'b0;
         penable_q     <= 1'b0;
         pwrite_q      <= 1'b0;
         paddr_q       <= '0;
         pwdata_q      <= '0;
         busy_q        <= 1'b0;
      end else begin
         state_q       <= state_d;
         idx_q         <= idx_d;
         cnt_q         <= cnt_d;
         op_q          <= op_d;
         width_q       <= width_d;
         data_q        <= data_d;
         noise_q       <= noise_d;
         rsp_valid_q   <= rsp_valid_d;
         rsp_data_q    <= rsp_data_d;
         rsp_nerr_q    <= rsp_nerr_d;
         rsp_timeout_q <= rsp_timeout_d;
         psel_q        <= psel_d;
         penable_q     <= penable_d;
         pwrite_q      <= pwrite_d;
         paddr_q       <= paddr_d;
         pwdata_q      <= pwdata_d;
         busy_q        <= busy_d;
      end
   end

   always_comb begin
      state_d       = state_q;
      idx_d         = idx_q;
      cnt_d         = cnt_q;
      op_d          = op_q;
      width_d       = width_q;
      data_d        = data_q;
      noise_d       = noise_q;
      rsp_valid_d   = rsp_valid_q;
      rsp_data_d    = rsp_data_q;
      rsp_nerr_d    = rsp_nerr_q;
      rsp_timeout_d = rsp_timeout_q;

      case (state_q)
         S_IDLE: begin
            if (cmd_valid && cmd_ready) begin
               op_d    = cmd_op;
               width_d = cmd_width;
               data_d  = cmd_data;
               noise_d = cmd_noise;
               idx_d   = IDX_WIDTH;
               state_d = S_SETUP;
            end
         end
         S_SETUP: state_d = S_ACCESS;
         S_ACCESS: begin
            // CTRL access kicks off the ECC block, so it always closes the burst
            if (idx_q == IDX_CTRL) begin
               cnt_d   = '0;
               state_d = S_WAIT_DONE;
            end else begin
               case (idx_q)
                  IDX_WIDTH: idx_d = (op_q == OP_FULL) ? IDX_NOISE : IDX_DATA;
                  IDX_NOISE: idx_d = IDX_DATA;
                  default:   idx_d = IDX_CTRL;
               endcase
               state_d = S_SETUP;
            end
         end
         S_WAIT_DONE: begin
            if (operation_done) begin
               rsp_data_d    = data_out;
               rsp_nerr_d    = num_of_errors;
               rsp_timeout_d = 1'b0;
               rsp_valid_d   = 1'b1;
               state_d       = S_RESP;
            end else if (cnt_q == CNT_LAST) begin
               rsp_data_d    = '0;
               rsp_nerr_d    = '0;
               rsp_timeout_d = 1'b1;
               rsp_valid_d   = 1'b1;
               state_d       = S_RESP;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         S_RESP: begin
            if (rsp_ready) begin
               rsp_valid_d = 1'b0;
               state_d     = S_IDLE;
            end
         end
         default: state_d = S_IDLE;
      endcase

      // Bus outputs are registered from the next state so they align with it
      bus_act   = (state_d == S_SETUP) || (state_d == S_ACCESS);
      psel_d    = bus_act;
      penable_d = (state_d == S_ACCESS);
      pwrite_d  = bus_act;
      paddr_d   = bus_act ? entry_addr(idx_d) : '0;
      pwdata_d  = bus_act ? entry_data(idx_d, op_d, width_d, data_d, noise_d) : '0;
      busy_d    = (state_d != S_IDLE);
   end

   assign PADDR       = paddr_q;
   assign PWDATA      = pwdata_q;
   assign PSEL        = psel_q;
   assign PENABLE     = penable_q;
   assign PWRITE      = pwrite_q;
   assign rsp_valid   = rsp_valid_q;
   assign rsp_data    = rsp_data_q;
   assign rsp_nerr    = rsp_nerr_q;
   assign rsp_timeout = rsp_timeout_q;
   assign busy        = busy_q;

endmodule

// File: tb/tb_ecc_apb_cmd_seq.sv
// Scoreboard bench for ecc_apb_cmd_seq: a driver issues jobs, an ECC stub answers
// them, and a monitor checks the APB writes and responses against queued expectations.
module tb_ecc_apb_cmd_seq;

   localparam int AW = 20;
   localparam int W  = 32;
   localparam int DW = 32;
   localparam int TO = 16;

   logic          clk = 1'b0;
   logic          rst;
   logic          cmd_valid;
   logic          cmd_ready;
   logic [1:0]    cmd_op;
   logic [1:0]    cmd_width;
   logic [W-1:0]  cmd_data;
   logic [W-1:0]  cmd_noise;
   logic [AW-1:0] PADDR;
   logic [W-1:0]  PWDATA;
   logic          PSEL;
   logic          PENABLE;
   logic          PWRITE;
   logic          operation_done;
   logic [DW-1:0] data_out;
   logic [1:0]    num_of_errors;
   logic          rsp_valid;
   logic          rsp_ready;
   logic [DW-1:0] rsp_data;
   logic [1:0]    rsp_nerr;
   logic          rsp_timeout;
   logic          busy;

   ecc_apb_cmd_seq #(
      .AMBA_ADDR_WIDTH(AW),
      .AMBA_WORD      (W),
      .DATA_WIDTH     (DW),
      .TIMEOUT_CYCLES (TO)
   ) dut (
      .clk           (clk),
      .rst           (rst),
      .cmd_valid     (cmd_valid),
      .cmd_ready     (cmd_ready),
      .cmd_op        (cmd_op),
      .cmd_width     (cmd_width),
      .cmd_data      (cmd_data),
      .cmd_noise     (cmd_noise),
      .PADDR         (PADDR),
      .PWDATA        (PWDATA),
      .PSEL          (PSEL),
      .PENABLE       (PENABLE),
      .PWRITE        (PWRITE),
      .operation_done(operation_done),
      .data_out      (data_out),
      .num_of_errors (num_of_errors),
      .rsp_valid     (rsp_valid),
      .rsp_ready     (rsp_ready),
      .rsp_data      (rsp_data),
      .rsp_nerr      (rsp_nerr),
      .rsp_timeout   (rsp_timeout),
      .busy          (busy)
   );

   always #5 clk = ~clk;

   typedef struct { logic [AW-1:0] addr; logic [W-1:0] data; } wr_t;
   typedef struct { int k; logic [DW-1:0] dout; logic [1:0] nerr; bit stale; } stub_t;
   typedef struct { logic [DW-1:0] data; logic [1:0] nerr; logic to; int cyc; } rsp_t;
   typedef struct { int cyc; logic [1:0] op; } acc_t;

   wr_t   wr_q[$];
   stub_t stub_q[$];
   rsp_t  rsp_q[$];
   acc_t  acc_q[$];

   int n_chk  = 0;
   int n_pass = 0;
   int cyc    = 0;
   bit bp_req = 1'b0;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: actual=%0h expected=%0h (cyc %0d)", name, act, exp, cyc);
   endtask

   task automatic note_fail(input string name);
      n_chk++;
      $display("FAIL %s: actual=missing expected=present (cyc %0d)", name, cyc);
   endtask

   // Called at posedge+1; returns at posedge+1 after the accepting edge with cmd_valid low
   task automatic send(input logic [1:0] op, input logic [1:0] wd, input logic [W-1:0] d,
                       input logic [W-1:0] nz, input int k, input logic [DW-1:0] dout,
                       input logic [1:0] nerr, input bit stale);
      int    n;
      wr_t   e;
      stub_t s;
      acc_t  a;
      cmd_valid = 1'b1;
      cmd_op    = op;
      cmd_width = wd;
      cmd_data  = d;
      cmd_noise = nz;
      n = 0;
      forever begin
         @(negedge clk);
         if (cmd_ready) break;
         n++;
         if (n >= 300) break;
      end
      if (!cmd_ready) begin
         note_fail("cmd_accept");
      end else begin
         e = '{addr: AW'(8'h08), data: W'(wd)}; wr_q.push_back(e);
         if (op == 2'b10) begin e = '{addr: AW'(8'h0C), data: nz}; wr_q.push_back(e); end
         e = '{addr: AW'(8'h04), data: d};      wr_q.push_back(e);
         e = '{addr: AW'(8'h00), data: W'(op)}; wr_q.push_back(e);
         s = '{k: k, dout: dout, nerr: nerr, stale: stale}; stub_q.push_back(s);
         a = '{cyc: cyc, op: op}; acc_q.push_back(a);
      end
      @(posedge clk); #1;
      cmd_valid = 1'b0;
   endtask

   // ECC stub: answers k cycles after WAIT_DONE entry (k=0: never) and predicts the response
   initial begin : stub
      int            cnt;
      bit            armed;
      stub_t         s;
      rsp_t          r;
      acc_t          a;
      logic [DW-1:0] pend_d;
      logic [1:0]    pend_n;
      operation_done = 1'b0;
      data_out       = '0;
      num_of_errors  = '0;
      armed = 1'b0;
      cnt   = 0;
      pend_d = '0;
      pend_n = '0;
      forever begin
         @(negedge clk);
         operation_done = 1'b0;
         if (rst) begin
            armed = 1'b0;
         end else begin
            if (armed) begin
               cnt--;
               if (cnt == 0) begin
                  operation_done = 1'b1;
                  data_out       = pend_d;
                  num_of_errors  = pend_n;
                  armed          = 1'b0;
               end
            end
            if (PSEL && !PENABLE && PADDR == AW'(8'h04) && stub_q.size() > 0 && stub_q[0].stale) begin
               operation_done = 1'b1;
               data_out       = DW'($urandom);
               num_of_errors  = 2'($urandom);
            end
            if (PSEL && PENABLE && PADDR == AW'(0)) begin
               if (stub_q.size() == 0) begin
                  note_fail("stub_cfg");
               end else begin
                  s = stub_q.pop_front();
                  if (acc_q.size() == 0) note_fail("accept_record");
                  else begin
                     a = acc_q.pop_front();
                     chk("job_length", 64'(cyc - a.cyc), 64'((a.op == 2'b10) ? 8 : 6));
                  end
                  if (s.k >= 1 && s.k <= TO) r = '{data: s.dout, nerr: s.nerr, to: 1'b0, cyc: cyc + 1 + s.k};
                  else                       r = '{data: '0, nerr: 2'b00, to: 1'b1, cyc: cyc + 1 + TO};
                  rsp_q.push_back(r);
                  if (s.k > 0) begin
                     armed  = 1'b1;
                     cnt    = s.k;
                     pend_d = s.dout;
                     pend_n = s.nerr;
                  end
               end
            end
         end
      end
   end

   // Response consumer: random readiness, optional 5-cycle stall on request
   initial begin : rdy
      int hold;
      hold = 0;
      rsp_ready = 1'b0;
      forever begin
         @(posedge clk); #1;
         if (bp_req && rsp_valid && hold == 0) begin
            hold   = 5;
            bp_req = 1'b0;
         end
         if (hold > 0) begin
            rsp_ready = 1'b0;
            hold--;
         end else begin
            rsp_ready = ($urandom_range(0, 3) != 0);
         end
      end
   end

   // Monitor: bus protocol, write order, response payload/latency, busy and cmd_ready
   initial begin : mon
      bit   exp_busy, have_cur, prev_setup;
      rsp_t cur;
      wr_t  e;
      exp_busy = 1'b0;
      have_cur = 1'b0;
      prev_setup = 1'b0;
      cur = '{data: '0, nerr: '0, to: 1'b0, cyc: 0};
      forever begin
         @(negedge clk);
         chk("busy", 64'(busy), 64'(exp_busy));
         chk("cmd_ready", 64'(cmd_ready), 64'(!exp_busy && !rst));
         if (!PSEL) begin
            chk("bus_idle", 64'({PENABLE, PWRITE, PADDR, PWDATA}), 64'(0));
            prev_setup = 1'b0;
         end else if (!PENABLE) begin
            if (wr_q.size() == 0) note_fail("setup_expected");
            else chk("setup_phase", 64'({PWRITE, PADDR, PWDATA}), 64'({1'b1, wr_q[0].addr, wr_q[0].data}));
            prev_setup = 1'b1;
         end else begin
            chk("access_after_setup", 64'(prev_setup), 64'(1));
            if (wr_q.size() == 0) note_fail("access_expected");
            else begin
               e = wr_q.pop_front();
               chk("access_phase", 64'({PWRITE, PADDR, PWDATA}), 64'({1'b1, e.addr, e.data}));
            end
            prev_setup = 1'b0;
         end
         if (rsp_valid) begin
            if (!have_cur) begin
               if (rsp_q.size() == 0) note_fail("rsp_expected");
               else begin
                  cur = rsp_q.pop_front();
                  have_cur = 1'b1;
                  chk("rsp_latency", 64'(cyc), 64'(cur.cyc));
               end
            end
            if (have_cur)
               chk("rsp_payload", 64'({rsp_timeout, rsp_nerr, rsp_data}), 64'({cur.to, cur.nerr, cur.data}));
            if (rsp_ready) have_cur = 1'b0;
         end
         if (rst) begin
            exp_busy = 1'b0;
            have_cur = 1'b0;
         end else if (cmd_valid && cmd_ready) exp_busy = 1'b1;
         else if (rsp_valid && rsp_ready)     exp_busy = 1'b0;
      end
   end

   initial begin : drv
      int  n, k, sel;
      rst       = 1'b1;
      cmd_valid = 1'b0;
      cmd_op    = '0;
      cmd_width = '0;
      cmd_data  = '0;
      cmd_noise = '0;
      repeat (3) @(posedge clk);
      #1;
      rst = 1'b0;
      @(negedge clk);
      chk("reset_cmd_ready", 64'(cmd_ready), 64'(1));
      chk("reset_outputs", 64'({PSEL, PENABLE, rsp_valid, rsp_timeout, busy, rsp_nerr}), 64'(0));
      chk("reset_rsp_data", 64'(rsp_data), 64'(0));
      @(posedge clk); #1;

      send(2'b00, 2'b00, 32'h5, 32'hFFFF_0000, 2, 32'h2D, 2'b00, 1'b0);        // encode
      send(2'b10, 2'b01, 32'h1234_ABCD, 32'h1, 3, 32'hCAFE_F00D, 2'b01, 1'b0); // full channel
      send(2'b00, 2'b10, 32'hA5A5_5A5A, 32'h0, 0, 32'h0, 2'b00, 1'b0);         // timeout
      bp_req = 1'b1;
      send(2'b01, 2'b00, 32'h77, 32'h0, 5, 32'h1111_2222, 2'b10, 1'b0);
      send(2'b00, 2'b00, 32'h3C, 32'h0, 1, 32'h3333_4444, 2'b00, 1'b0);
      send(2'b01, 2'b10, 32'hDEAD_BEEF, 32'h0, 4, 32'h5555_6666, 2'b11, 1'b1); // stale done
      send(2'b01, 2'b01, 32'h0F0F, 32'h0, TO, 32'h7777_8888, 2'b01, 1'b0);      // done on last cycle
      send(2'b11, 2'b11, 32'h1, 32'h2, TO + 1, 32'h9999_AAAA, 2'b10, 1'b0);     // one cycle too late

      // Reset while the DATA_IN write is in its access phase
      send(2'b00, 2'b10, 32'hBEEF, 32'h0, 3, 32'h1, 2'b01, 1'b0);
      n = 0;
      while (!(PSEL && PENABLE && PADDR == AW'(8'h04)) && n < 50) begin
         @(posedge clk); #1;
         n++;
      end
      if (n >= 50) note_fail("data_in_access");
      rst = 1'b1;
      @(posedge clk); #1;
      wr_q.delete();
      stub_q.delete();
      acc_q.delete();
      @(negedge clk);
      chk("rst_abort_bus", 64'({PSEL, PENABLE}), 64'(0));
      chk("rst_abort_busy", 64'(busy), 64'(0));
      chk("rst_abort_rsp", 64'(rsp_valid), 64'(0));
      @(posedge clk); #1;
      rst = 1'b0;
      @(negedge clk);
      chk("rst_abort_ready", 64'(cmd_ready), 64'(1));
      @(posedge clk); #1;

      for (int i = 0; i < 30; i++) begin
         sel = $urandom_range(0, 9);
         if (sel == 0)      k = 0;
         else if (sel == 1) k = TO;
         else if (sel == 2) k = TO + 1;
         else               k = $urandom_range(1, 20);
         if (i % 7 == 3) bp_req = 1'b1;
         send(2'($urandom), 2'($urandom), W'($urandom), W'($urandom), k,
              DW'($urandom), 2'($urandom), 1'($urandom_range(0, 1)));
      end

      n = 0;
      while ((rsp_q.size() != 0 || wr_q.size() != 0 || stub_q.size() != 0 || busy) && n < 3000) begin
         @(posedge clk); #1;
         n++;
      end
      if (n >= 3000) note_fail("drain");
      repeat (5) @(posedge clk);
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule

// File: doc/ecc_apb_cmd_seq.md
Name: ecc_apb_cmd_seq

Overview:
Upstream command sequencer for the ECC encoder/decoder block. It accepts one ECC job per valid/ready handshake (operation, codeword width, data, noise) and issues the APB register-write sequence that programs and starts the ECC block. It then waits for operation_done, captures data_out and num_of_errors, and returns them on a valid/ready response port. A timeout guards against a missing completion.

Parameters:
AMBA_ADDR_WIDTH, 20, PADDR width
AMBA_WORD, 32, PWDATA and command data/noise width
DATA_WIDTH, 32, width of the ECC data_out captured into the response
TIMEOUT_CYCLES, 16, WAIT_DONE cycles allowed before a timeout response (minimum 2)

Ports:
clk  in  1  clock; all logic on its rising edge
rst  in  1  synchronous, active-high reset
cmd_valid  in  1  command present
cmd_ready  out  1  command accepted when high together with cmd_valid
cmd_op  in  2  CTRL value: 00 encode, 01 decode, 10 full channel
cmd_width  in  2  CODEWORD_WIDTH value: 00 = 8b, 01 = 16b, 10 = 32b
cmd_data  in  AMBA_WORD  DATA_IN value
cmd_noise  in  AMBA_WORD  NOISE value; used only when cmd_op = 10
PADDR  out  AMBA_ADDR_WIDTH  APB address
PWDATA  out  AMBA_WORD  APB write data
PSEL  out  1  APB select
PENABLE  out  1  APB enable
PWRITE  out  1  APB write
operation_done  in  1  completion pulse from the ECC block
data_out  in  DATA_WIDTH  ECC result
num_of_errors  in  2  ECC error count
rsp_valid  out  1  response present
rsp_ready  in  1  response consumed
rsp_data  out  DATA_WIDTH  captured data_out
rsp_nerr  out  2  captured num_of_errors
rsp_timeout  out  1  high if the job timed out
busy  out  1  high whenever state != IDLE

Behaviour:
- Reset (rst high at an edge): state IDLE; all outputs 0 except cmd_ready; command latches and timeout counter cleared. Reset mid-transaction aborts at that edge with no response. cmd_ready = (state == IDLE) & ~rst.
- States: IDLE, SETUP, ACCESS, WAIT_DONE, RESP.
- IDLE: on cmd_valid & cmd_ready, latch cmd_op, cmd_width, cmd_data and cmd_noise, set write index to 0, go to SETUP.
- Write list, in order:
  - 0: PADDR 0x08, PWDATA = zero-extended cmd_width
  - 1: PADDR 0x0C, PWDATA = cmd_noise; skipped unless op = 10
  - 2: PADDR 0x04, PWDATA = cmd_data
  - 3: PADDR 0x00, PWDATA = zero-extended cmd_op
  - CTRL is always written last, because a CTRL access phase starts the ECC block.
- SETUP (1 cycle): PSEL=1, PENABLE=0, PWRITE=1, PADDR/PWDATA = current entry. Next state ACCESS.
- ACCESS (1 cycle): PSEL=1, PENABLE=1, PADDR/PWDATA/PWRITE unchanged from SETUP. No wait states (the target has no PREADY).
  - If the entry just written was CTRL: go to WAIT_DONE, timeout counter = 0.
  - Otherwise: advance to the next non-skipped entry, go to SETUP.
- Bus idle in all other states: PSEL=PENABLE=PWRITE=0, PADDR=0, PWDATA=0.
- Job length from acceptance to the WAIT_DONE entry edge: 6 cycles for op 00/01, 8 cycles for op 10.
- operation_done is ignored in all states except WAIT_DONE; stale pulses are discarded.
- WAIT_DONE:
  - operation_done=1: rsp_data <= data_out, rsp_nerr <= num_of_errors, rsp_timeout <= 0, rsp_valid <= 1, go to RESP.
  - Else if counter == TIMEOUT_CYCLES-1: rsp_data <= 0, rsp_nerr <= 0, rsp_timeout <= 1, rsp_valid <= 1, go to RESP.
  - Otherwise counter +1 (saturating).
  - Done and timeout in the same cycle: done wins.
- RESP: rsp_* held stable while rsp_valid & ~rsp_ready. On rsp_ready, rsp_valid <= 0 and go to IDLE. The next command can be accepted 1 cycle after the response handshake (no bypass).
- op 11 and width 11 are passed through verbatim; no checking is done.

Test Plan:
- Encode, op=00 width=00 data=0x5; stub raises operation_done 2 cycles after the CTRL ACCESS with data_out=0x2D, num_of_errors=00 -> writes (0x08,0x0), (0x04,0x5), (0x00,0x0), each SETUP then ACCESS, no NOISE write; rsp_data=0x2D, rsp_nerr=00, rsp_timeout=0.
- Full channel, op=10 width=01 noise=0x00000001; stub returns num_of_errors=01 -> 4 writes in order 0x08, 0x0C, 0x04, 0x00 (8 bus cycles); rsp_nerr=01.
- Timeout, TIMEOUT_CYCLES=16; stub never asserts done -> rsp_valid rises exactly 16 cycles after WAIT_DONE entry, rsp_timeout=1, rsp_data=0.
- Backpressure: rsp_ready held low 5 cycles with a second cmd_valid pending -> rsp_* stable, cmd_ready=0 throughout; second command accepted 1 cycle after the rsp handshake.
- Stale done: operation_done pulsed during the DATA_IN SETUP -> ignored, and the real done is captured. Done coincident with the final timeout cycle -> rsp_timeout=0.
- rst asserted during the DATA_IN ACCESS -> next edge: PSEL=PENABLE=0, busy=0, rsp_valid=0, cmd_ready=1.
